// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one embedded-RAM port between two bus masters. Master 0 (pipeline
// data port) has fixed priority; master 1 (DMA/debug loader) is protected by
// a starvation counter that forces a master-1 win after M1_MAX_WAIT lost
// arbitrations (M1_MAX_WAIT = 0 keeps strict master-0 priority).
//
// One access is in flight at a time:
//   IDLE -> CMD -> ACK                 (write)
//   IDLE -> CMD -> WAIT x RD_LAT -> ACK (read)
// Read data appears on ram_r_line RD_LAT cycles after the CMD cycle and is
// captured at the end of the last WAIT cycle, so a read acks 2+RD_LAT cycles
// after the request is sampled in IDLE. A write acks 2 cycles after the
// sample, carrying the ram_exception value seen during CMD.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m{0,1}_req/_we/_addr/_wline   master request (held until ack)
//   m{0,1}_rline/_ack/_err        completion: one-cycle ack, data and error
//   ram_r_addr/_w_addr/_w_line    RAM address/data, held outside CMD
//   ram_read/ram_write            RAM strobes, high only during CMD
//   ram_r_line/ram_exception      RAM read data and exception flag
//   owner                         00 idle, 01 m0 active, 10 m1 active
//
// All outputs are registered and reset to zero.

module ram_port_arbiter #(
  parameter int RD_LAT      = 1,
  parameter int M1_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wline,
  output logic [31:0] m0_rline,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wline,
  output logic [31:0] m1_rline,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] ram_r_addr,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_line,
  output logic        ram_read,
  output logic        ram_write,
  input  logic [31:0] ram_r_line,
  input  logic        ram_exception,
  output logic [1:0]  owner
);

  localparam logic [3:0] LAT_LAST   = 4'(RD_LAT - 1);
  localparam logic [7:0] MAX_WAIT_C = 8'(M1_MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state_q;
  logic        sel_q;        // winner of the current access: 0 = m0, 1 = m1
  logic        we_q;
  logic [3:0]  lat_cnt_q;
  logic [7:0]  wait_cnt_q;

  logic [31:0] m_rline_q [2];
  logic        m_ack_q   [2];
  logic        m_err_q   [2];
  logic [31:0] ram_r_addr_q;
  logic [31:0] ram_w_addr_q;
  logic [31:0] ram_w_line_q;
  logic        ram_read_q;
  logic        ram_write_q;
  logic [1:0]  owner_q;

  // Arbitration decision for the current IDLE cycle
  logic        force_m1_d;
  logic        m1_wins_d;
  logic        start_d;
  logic        we_d;
  logic [31:0] addr_d;
  logic [31:0] wline_d;
  logic [7:0]  wait_cnt_d;

  always_comb begin
    force_m1_d = (M1_MAX_WAIT != 0) && (wait_cnt_q >= MAX_WAIT_C);
    m1_wins_d  = m1_req && (!m0_req || force_m1_d);
    start_d    = m0_req || m1_req;
    we_d       = m1_wins_d ? m1_we    : m0_we;
    addr_d     = m1_wins_d ? m1_addr  : m0_addr;
    wline_d    = m1_wins_d ? m1_wline : m0_wline;

    // m1 pending and losing to m0 is the only case that ages the counter
    wait_cnt_d = 8'd0;
    if (m1_req && !m1_wins_d) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      lat_cnt_q    <= 4'd0;
      wait_cnt_q   <= 8'd0;
      for (int i = 0; i < 2; i++) begin
        m_rline_q[i] <= 32'd0;
        m_ack_q[i]   <= 1'b0;
        m_err_q[i]   <= 1'b0;
      end
      ram_r_addr_q <= 32'd0;
      ram_w_addr_q <= 32'd0;
      ram_w_line_q <= 32'd0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      owner_q      <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_cnt_q <= wait_cnt_d;
          if (start_d) begin
            sel_q        <= m1_wins_d;
            we_q         <= we_d;
            ram_r_addr_q <= addr_d;
            ram_w_addr_q <= addr_d;
            ram_w_line_q <= wline_d;
            ram_read_q   <= !we_d;
            ram_write_q  <= we_d;
            owner_q      <= m1_wins_d ? 2'b10 : 2'b01;
            state_q      <= S_CMD;
          end
        end

        S_CMD: begin
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          if (we_q) begin
            // Write exceptions are reported during the strobe cycle itself
            m_err_q[sel_q] <= ram_exception;
            m_ack_q[sel_q] <= 1'b1;
            state_q        <= S_ACK;
          end else begin
            lat_cnt_q <= LAT_LAST;
            state_q   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            m_rline_q[sel_q] <= ram_r_line;
            m_err_q[sel_q]   <= ram_exception;
            m_ack_q[sel_q]   <= 1'b1;
            state_q          <= S_ACK;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end

        S_ACK: begin
          m_ack_q[0] <= 1'b0;
          m_ack_q[1] <= 1'b0;
          owner_q    <= 2'b00;
          state_q    <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_rline   = m_rline_q[0];
  assign m0_ack     = m_ack_q[0];
  assign m0_err     = m_err_q[0];
  assign m1_rline   = m_rline_q[1];
  assign m1_ack     = m_ack_q[1];
  assign m1_err     = m_err_q[1];
  assign ram_r_addr = ram_r_addr_q;
  assign ram_w_addr = ram_w_addr_q;
  assign ram_w_line = ram_w_line_q;
  assign ram_read   = ram_read_q;
  assign ram_write  = ram_write_q;
  assign owner      = owner_q;

endmodule
